// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU opcodes,
// forward-select encodings and the hard-wired zero register.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b10;
    localparam logic [1:0] FWD_MWB = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding for one ALU source: picks EX/MEM, MEM/WB or the
// registered value. Ports: valid/src/value in, bypass buses in, sel/data out.
module fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              valid,
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] value,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] exm_dest,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_regwrite,
    input  logic [REG_AW-1:0] mwb_dest,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] data
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    logic hit_exm;
    logic hit_mwb;

    assign hit_exm = valid && exm_regwrite &&
                     (exm_dest != ZERO) && (exm_dest == src);
    assign hit_mwb = valid && mwb_regwrite &&
                     (mwb_dest != ZERO) && (mwb_dest == src);

    // The younger producer (EX/MEM) takes precedence.
    always_comb begin
        sel  = FWD_REG;
        data = value;
        if (hit_exm) begin
            sel  = FWD_EXM;
            data = exm_result;
        end else if (hit_mwb) begin
            sel  = FWD_MWB;
            data = mwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture bypass, forwarding and load-use
// detection. Ports: ID bundle in, EX/MEM + MEM/WB bypass in, EX bundle out.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_instru,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_read1,
    input  logic [DATA_W-1:0] id_read2,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regdst,
    input  logic              id_alusrc,
    input  logic [3:0]        id_alucontrol,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] exm_dest,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_regwrite,
    input  logic [REG_AW-1:0] mwb_dest,
    input  logic [DATA_W-1:0] mwb_data,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_read2,
    output logic [DATA_W-1:0] ex_instru,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic [3:0]        ex_alucontrol,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    logic [DATA_W-1:0] read1_q;
    logic [DATA_W-1:0] read2_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [DATA_W-1:0] cap_read1;
    logic [DATA_W-1:0] cap_read2;
    logic              wb_rs;
    logic              wb_rt;
    logic              bubble;

    assign hazard_stall = ex_valid && ex_memread && (ex_dest != ZERO) &&
                          ((ex_dest == id_rs) || (ex_dest == id_rt)) &&
                          id_valid && !ex_hold;

    // Regfile write-then-read in the same cycle: take the WB value.
    assign wb_rs = mwb_regwrite && (mwb_dest != ZERO) && (mwb_dest == id_rs);
    assign wb_rt = mwb_regwrite && (mwb_dest != ZERO) && (mwb_dest == id_rt);
    assign cap_read1 = wb_rs ? mwb_data : id_read1;
    assign cap_read2 = wb_rt ? mwb_data : id_read2;

    assign bubble = flush || hazard_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_instru     <= '0;
            ex_pc_plus4   <= '0;
            read1_q       <= '0;
            read2_q       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            ex_dest       <= '0;
            ex_alusrc     <= 1'b0;
            ex_regwrite   <= 1'b0;
            ex_memread    <= 1'b0;
            ex_memwrite   <= 1'b0;
            ex_memtoreg   <= 1'b0;
            ex_alucontrol <= '0;
        end else if (!ex_hold) begin
            if (bubble) begin
                ex_valid      <= 1'b0;
                ex_instru     <= '0;
                ex_pc_plus4   <= '0;
                read1_q       <= '0;
                read2_q       <= '0;
                rs_q          <= '0;
                rt_q          <= '0;
                ex_dest       <= '0;
                ex_alusrc     <= 1'b0;
                ex_regwrite   <= 1'b0;
                ex_memread    <= 1'b0;
                ex_memwrite   <= 1'b0;
                ex_memtoreg   <= 1'b0;
                ex_alucontrol <= '0;
            end else begin
                ex_valid      <= id_valid;
                ex_instru     <= id_instru;
                ex_pc_plus4   <= id_pc_plus4;
                read1_q       <= cap_read1;
                read2_q       <= cap_read2;
                rs_q          <= id_rs;
                rt_q          <= id_rt;
                ex_dest       <= id_regdst ? id_rd : id_rt;
                ex_alusrc     <= id_valid & id_alusrc;
                ex_regwrite   <= id_valid & id_regwrite;
                ex_memread    <= id_valid & id_memread;
                ex_memwrite   <= id_valid & id_memwrite;
                ex_memtoreg   <= id_valid & id_memtoreg;
                ex_alucontrol <= id_valid ? id_alucontrol : 4'b0000;
            end
        end
    end

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .valid        (ex_valid),
        .src          (rs_q),
        .value        (read1_q),
        .exm_regwrite (exm_regwrite),
        .exm_dest     (exm_dest),
        .exm_result   (exm_result),
        .mwb_regwrite (mwb_regwrite),
        .mwb_dest     (mwb_dest),
        .mwb_data     (mwb_data),
        .sel          (fwd_a),
        .data         (ex_data1)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .valid        (ex_valid),
        .src          (rt_q),
        .value        (read2_q),
        .exm_regwrite (exm_regwrite),
        .exm_dest     (exm_dest),
        .exm_result   (exm_result),
        .mwb_regwrite (mwb_regwrite),
        .mwb_dest     (mwb_dest),
        .mwb_data     (mwb_data),
        .sel          (fwd_b),
        .data         (ex_read2)
    );

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with operand forwarding and load-use hazard detection.
- Captures decoded operands and control from ID and drives the EX-stage ALU (data1, read2, instru, ALUSrc, ALUcontrol).
- Selects forwarded operands from EX/MEM and MEM/WB.
- Inserts bubbles on load-use hazard or flush; freezes on downstream hold.

Parameters:
DATA_W, 32, datapath width (ALU is 32-bit; only 32 supported)
REG_AW, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_instru  in  DATA_W  instruction word (ALU sign-extends [15:0])
id_pc_plus4  in  DATA_W  PC+4 of instruction
id_read1  in  DATA_W  regfile rs data
id_read2  in  DATA_W  regfile rt data
id_rs  in  REG_AW  rs index
id_rt  in  REG_AW  rt index
id_rd  in  REG_AW  rd index
id_regdst  in  1  1: dest=rd, 0: dest=rt
id_alusrc  in  1  ALU operand-2 select
id_alucontrol  in  4  ALU opcode
id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  control bits
flush  in  1  branch/jump squash of ID instruction
ex_hold  in  1  downstream stall; freeze this stage
exm_regwrite  in  1  EX/MEM writes register
exm_dest  in  REG_AW  EX/MEM destination
exm_result  in  DATA_W  EX/MEM ALU result
mwb_regwrite  in  1  MEM/WB writes register
mwb_dest  in  REG_AW  MEM/WB destination
mwb_data  in  DATA_W  MEM/WB writeback data
hazard_stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_data1  out  DATA_W  forwarded operand A to ALU
ex_read2  out  DATA_W  forwarded operand B to ALU; also store data
ex_instru, ex_pc_plus4  out  DATA_W  registered copies
ex_dest  out  REG_AW  resolved destination (regdst applied at capture)
ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control
ex_alucontrol  out  4  registered ALU opcode
fwd_a, fwd_b  out  2  forward select: 00 reg, 10 EX/MEM, 01 MEM/WB

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0; ex_valid=0. Reset mid-operation drops the in-flight instruction.
- hazard_stall (combinational): ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt) & id_valid & !ex_hold.
- Per rising edge, priority order:
  - ex_hold=1: all registers retain value. Flush and stall are ignored; upstream holds flush until hold drops.
  - else flush=1: load bubble (ex_valid=0, all control bits 0, alucontrol 0, data fields don't-care but written 0).
  - else hazard_stall=1: load bubble. ID is held upstream and captured the following cycle.
  - else: capture ID. ex_valid=id_valid; control is zeroed when id_valid=0.
- Capture bypass: if mwb_regwrite & mwb_dest!=0 & mwb_dest==id_rs, captured data1 = mwb_data. Same rule for rt/read2. This covers a regfile write and read in the same cycle.
- Forwarding (combinational on registered rs/rt):
  - EX/MEM wins when exm_regwrite & exm_dest!=0 & exm_dest==rs.
  - Otherwise MEM/WB when mwb_regwrite & mwb_dest!=0 & mwb_dest==rs.
  - Otherwise the registered value. Same rule for rt.
  - Register 0 is never forwarded.
  - Forwarding is suppressed (select 00) when ex_valid=0.
- ex_read2 is always the forwarded rt value; ALU applies ALUSrc itself.
- Latency: one cycle ID->EX; forwarding adds zero cycles. A load-use pair costs exactly one bubble.

Decomposition:
- Shared package: ALU opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100), forward-select encodings, REG_ZERO.
- One sub-module: fwd_unit, the combinational forward-select plus mux, instantiated for A and B.

Test Plan:
- Reset: rst_n low mid-stream with ex_valid=1 -> all outputs 0 immediately; first instruction after release appears one cycle later.
- EX/MEM forward: add $3 in EX/MEM (exm_result=0x0000_0010); ID sub rs=$3, id_read1=0x5 -> next cycle fwd_a=10, ex_data1=0x10.
- Double hazard: $4 written in both EX/MEM (0xAA) and MEM/WB (0xBB) -> fwd_b=10, ex_read2=0xAA. Dest $0 with exm_result=0xFF -> fwd=00.
- Load-use: lw $5 in EX (ex_memread=1, ex_dest=5); ID add rs=$5 -> hazard_stall=1 for one cycle, bubble next (ex_valid=0, regwrite=0), then add captured with MEM/WB forward.
- Flush vs stall: flush=1 and hazard_stall=1 together -> bubble. ex_hold=1 with flush=1 -> registers unchanged; flush honoured after hold drops.
- Capture bypass: mwb writes $7=0x1234 while ID reads $7 with id_read1=0 -> ex_data1=0x1234 after capture, even once mwb_regwrite drops.
